// File: rtl/fir_serial_sym.sv
`default_nettype none
// ============================================================================
// fir_serial_sym : serial symmetric FIR, one coefficient pair per clock
//                  through a pre-add / multiply / accumulate pipeline.
// Optional macro : FIR_OUT_SAT_EN (saturate Yout when OUT_W < ACC_W; else wrap)
// Revision       : 1.0
// ============================================================================
module fir_serial_sym #(
  parameter int DW    = 12,
  parameter int CW    = 12,
  parameter int TAPS  = 16,
  parameter int OUT_W = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DW-1:0]         Xin,
  input  logic                         Xin_valid,
  output logic                         ready,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS/2)-1:0]    coef_addr,
  input  logic signed [CW-1:0]         coef_data,
  output logic signed [OUT_W-1:0]      Yout,
  output logic                         Yout_valid
);

  localparam int c_N     = TAPS / 2;
  localparam int c_KW    = $clog2(c_N);
  localparam int c_XW    = c_KW + 1;
  localparam int c_PW    = DW + CW + 1;
  localparam int c_ACC_W = c_PW + c_KW;

  localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_N - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_MAC   = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]                r_state;
  logic [c_KW-1:0]           r_k;
  logic                      r_flush;
  logic signed [DW-1:0]      r_x [TAPS];
  logic signed [CW-1:0]      r_c [c_N];

  logic signed [DW:0]        r_pre;
  logic signed [CW-1:0]      r_coef;
  logic                      r_v1, r_first1, r_last1;
  logic signed [c_PW-1:0]    r_prod;
  logic                      r_v2, r_first2, r_last2;
  logic signed [c_ACC_W-1:0] r_acc;
  logic signed [OUT_W-1:0]   r_yout;

  logic                      w_accept;
  logic [c_XW-1:0]           w_lo, w_hi;
  logic signed [DW:0]        w_xa, w_xb;
  logic signed [c_ACC_W-1:0] w_acc_base, w_acc_next;
  logic signed [OUT_W-1:0]   w_y;

  assign ready      = (r_state == c_IDLE);
  assign Yout_valid = (r_state == c_DONE);
  assign Yout       = r_yout;
  assign w_accept   = Xin_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_k     <= '0;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_state <= c_MAC;
            r_k     <= '0;
          end
        end
        c_MAC: begin
          if (r_k == c_KLAST) begin
            r_state <= c_FLUSH;
            r_flush <= 1'b0;
          end else begin
            r_k <= r_k + c_KW'(1);
          end
        end
        c_FLUSH: begin
          if (r_flush) r_state <= c_DONE;
          r_flush <= 1'b1;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Coefficients share the IDLE window with sample acceptance, so a write in
  // the accept cycle is already in place when the first pair is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
      for (int i = 0; i < c_N; i++) r_c[i] <= '0;
    end else begin
      if (w_accept) begin
        r_x[0] <= Xin;
        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
      end
      if (coef_we && ready) r_c[coef_addr] <= coef_data;
    end
  end

  assign w_lo = {1'b0, r_k};
  assign w_hi = c_XW'(TAPS - 1) - w_lo;
  assign w_xa = (DW+1)'(r_x[w_lo]);
  assign w_xb = (DW+1)'(r_x[w_hi]);

  assign w_acc_base = r_first2 ? '0 : r_acc;
  assign w_acc_next = w_acc_base + c_ACC_W'(r_prod);

  // Stage tags travel with the data so the accumulator knows where a sample
  // starts and ends without consulting the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_coef   <= '0;
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_prod   <= '0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_acc    <= '0;
      r_yout   <= '0;
    end else begin
      r_pre    <= w_xa + w_xb;
      r_coef   <= r_c[r_k];
      r_v1     <= (r_state == c_MAC);
      r_first1 <= (r_k == '0);
      r_last1  <= (r_k == c_KLAST);

      r_prod   <= c_PW'(r_pre) * c_PW'(r_coef);
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;

      if (r_v2) r_acc <= w_acc_next;
      if (r_v2 && r_last2) r_yout <= w_y;
    end
  end

  generate
    if (OUT_W >= c_ACC_W) begin : g_out_sext
      assign w_y = OUT_W'(w_acc_next);
    end else begin : g_out_narrow
`ifdef FIR_OUT_SAT_EN
      localparam logic signed [OUT_W-1:0] c_MAX = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic signed [OUT_W-1:0] c_MIN = {1'b1, {(OUT_W-1){1'b0}}};
      logic [c_ACC_W-OUT_W:0] w_top;
      logic                   w_ovf;
      // In range only when every bit above the output sign matches it.
      assign w_top = w_acc_next[c_ACC_W-1:OUT_W-1];
      assign w_ovf = !((&w_top) || !(|w_top));
      assign w_y   = !w_ovf ? w_acc_next[OUT_W-1:0]
                            : (w_acc_next[c_ACC_W-1] ? c_MIN : c_MAX);
`else
      assign w_y = w_acc_next[OUT_W-1:0];
`endif
    end
  endgenerate

endmodule
`default_nettype wire
